cgra_pe: RTL and testbench
==========================

Name: cgra_pe

Overview:
- Single processing element (PE) of the coarse-grained reconfigurable array tile.
- Selects two of three 16-bit tile operands, or its own registered result, as ALU inputs A and B.
- Applies one of eight ALU operations chosen by a 7-bit configuration word and registers the result to pe_out.
- Configuration is static per context, driven by the tile's context memory; no handshake.

Parameters:
- DATA_W, 16, operand/result width (all data ports).
- CFG_W, 7, configuration word width; fixed layout below, other values unsupported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- op_0  input  DATA_W  tile operand 0 (neighbour/tile input 0).
- op_1  input  DATA_W  tile operand 1 (neighbour/tile input 1).
- op_2  input  DATA_W  tile operand 2 (PE local data input).
- pex_config  input  CFG_W  configuration word: [6:4] opcode, [3:2] B select, [1:0] A select.
- pe_out  output  DATA_W  registered ALU result.

Behaviour:
- Operand select codes (same for A and B): 00 = op_0, 01 = op_1, 10 = op_2, 11 = pe_out (feedback, enables accumulation).
- Opcodes:
  - 000 PASS: result = A.
  - 001 ADD: A + B.
  - 010 SUB: A − B.
  - 011 MUL: low 16 bits of A × B.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 SHL: A << B[3:0].
- Arithmetic is 16-bit two's complement; ADD/SUB/MUL wrap modulo 2^16 unless PE_SAT_EN is defined.
- Datapath: operand mux and ALU are combinational; pe_out is the only state.
- pe_out <= ALU result on every rising clk edge when reset = 1.
- Latency: exactly 1 cycle from operand/config change to pe_out.
- Reset: reset = 0 forces pe_out = 16'h0000 immediately (asynchronous), independent of clk. pe_out holds 0 while reset is low.
- Reset release: first capture occurs at the first rising edge with reset = 1.
- Reset mid-operation: any accumulated value is discarded; the feedback operand reads 0 after reset.
- Feedback (select 11): uses the pe_out value from before the current edge. No combinational loop.
- pex_config may change every cycle; each cycle's result uses that cycle's config and operands.
- A and B may select the same source; e.g. ADD with A = B = op_0 gives 2·op_0.
- No X propagation from unused operands; unselected inputs have no effect.

Optional Feature:
- Macro: PE_SAT_EN.
- When defined: ADD and SUB saturate to signed range. Positive overflow gives 16'h7FFF; negative overflow gives 16'h8000.
- When defined: MUL saturates the signed 32-bit product to the same bounds.
- Other ops are unaffected.
- When not defined: all arithmetic wraps modulo 2^16; no saturation logic is synthesized.

Decomposition:
- Shared package pe_pkg:
  - DATA_W and CFG_W constants.
  - Opcode localparams OP_PASS … OP_SHL.
  - Select localparams SEL_OP0, SEL_OP1, SEL_OP2, SEL_FB.
  - Config field bit positions.
- One sub-module, pe_alu: purely combinational; inputs A, B, opcode; output result. Contains the saturation logic under PE_SAT_EN.
- The top level contains the operand muxes and the output register.

Test Plan:
- Reset: hold reset = 0 with op_0 = 10000 and random config → pe_out = 0 with no clock edge needed. Pulse reset low mid-accumulation → pe_out drops to 0 asynchronously.
- ADD then accumulate:
  - Cycle 1: op_2 = 10000, op_0 = 10000, op_1 = 0, pex_config = 7'b0010010 (ADD, A = op_2, B = op_0) → pe_out = 20000 after the edge.
  - Cycle 2: op_1 = 10000, others 0, pex_config = 7'b0011101 (ADD, A = op_1, B = feedback) → pe_out = 30000.
- SUB/PASS: A = op_0 = 5, B = op_1 = 7, SUB → 16'hFFFE. PASS with A = op_2 = 16'hABCD → 16'hABCD.
- Logic/shift: op_0 = 16'hF0F0, op_1 = 16'h0FF0:
  - AND → 16'h00F0.
  - OR → 16'hFFF0.
  - XOR → 16'hFF00.
  - SHL op_0 by op_1[3:0] = 0 → 16'hF0F0.
- MUL: 300 × 300 → 90000 mod 65536 = 24464 without PE_SAT_EN; 16'h7FFF with PE_SAT_EN.
- Overflow: ADD 30000 + 30000 → 16'hEA60 without PE_SAT_EN; 16'h7FFF with it. SUB −30000 − 30000 → 16'h8000 with PE_SAT_EN.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants, config field layout and a saturation helper for the CGRA PE.
package pe_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CFG_W  = 7;

    // Config word layout: [6:4] opcode, [3:2] B select, [1:0] A select
    localparam int unsigned OPC_LSB  = 4;
    localparam int unsigned OPC_W    = 3;
    localparam int unsigned BSEL_LSB = 2;
    localparam int unsigned ASEL_LSB = 0;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPC_W-1:0] OP_PASS = 3'b000;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b010;
    localparam logic [OPC_W-1:0] OP_MUL  = 3'b011;
    localparam logic [OPC_W-1:0] OP_AND  = 3'b100;
    localparam logic [OPC_W-1:0] OP_OR   = 3'b101;
    localparam logic [OPC_W-1:0] OP_XOR  = 3'b110;
    localparam logic [OPC_W-1:0] OP_SHL  = 3'b111;

    localparam logic [SEL_W-1:0] SEL_OP0 = 2'b00;
    localparam logic [SEL_W-1:0] SEL_OP1 = 2'b01;
    localparam logic [SEL_W-1:0] SEL_OP2 = 2'b10;
    localparam logic [SEL_W-1:0] SEL_FB  = 2'b11;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    // Clamp a signed double-width value into the signed DATA_W range.
    function automatic logic [DATA_W-1:0] sat_clamp(input logic signed [2*DATA_W-1:0] v);
        if (v > 32'sd32767) begin
            return SAT_MAX;
        end else if (v < -32'sd32768) begin
            return SAT_MIN;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cgra_pe_if.sv
// Operand / config / result bundle between a tile and one CGRA PE.
interface cgra_pe_if import pe_pkg::*; ;

    logic [DATA_W-1:0] op_0;
    logic [DATA_W-1:0] op_1;
    logic [DATA_W-1:0] op_2;
    logic [CFG_W-1:0]  pex_config;
    logic [DATA_W-1:0] pe_out;

    // Tile side: drives operands and config, observes the result
    modport master (
        output op_0, op_1, op_2, pex_config,
        input  pe_out
    );

    // PE side
    modport slave (
        input  op_0, op_1, op_2, pex_config,
        output pe_out
    );

endinterface

// File: rtl/pe_alu.sv
// Combinational 8-op ALU for the CGRA PE.
// Optional macro PE_SAT_EN: ADD/SUB/MUL saturate to the signed 16-bit range.
module pe_alu import pe_pkg::*; (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OPC_W-1:0]  opcode_i,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] sub_res;
    logic [DATA_W-1:0] mul_res;

`ifdef PE_SAT_EN
    logic signed [DATA_W:0]     add_w;
    logic signed [DATA_W:0]     sub_w;
    logic signed [2*DATA_W-1:0] mul_w;

    // One extra bit holds any ADD/SUB result exactly, so the clamp sees the true value
    assign add_w   = $signed({a_i[DATA_W-1], a_i}) + $signed({b_i[DATA_W-1], b_i});
    assign sub_w   = $signed({a_i[DATA_W-1], a_i}) - $signed({b_i[DATA_W-1], b_i});
    assign mul_w   = $signed(a_i) * $signed(b_i);
    assign add_res = sat_clamp({{(DATA_W-1){add_w[DATA_W]}}, add_w});
    assign sub_res = sat_clamp({{(DATA_W-1){sub_w[DATA_W]}}, sub_w});
    assign mul_res = sat_clamp(mul_w);
`else
    // Modulo 2^16: the low half of the product is the same for signed and unsigned
    assign add_res = a_i + b_i;
    assign sub_res = a_i - b_i;
    assign mul_res = a_i * b_i;
`endif

    // Opcode decode
    always_comb begin
        result_o = '0;
        unique case (opcode_i)
            OP_PASS: result_o = a_i;
            OP_ADD:  result_o = add_res;
            OP_SUB:  result_o = sub_res;
            OP_MUL:  result_o = mul_res;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SHL:  result_o = a_i << b_i[3:0];
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/cgra_pe.sv
// CGRA processing element: operand muxes, pe_alu and the registered result.
// Optional macro PE_SAT_EN (handled in pe_alu) enables saturating arithmetic.
module cgra_pe import pe_pkg::*; (
    input logic         clk,
    input logic         reset,
    cgra_pe_if.slave    bus
);

    logic [OPC_W-1:0]  opcode;
    logic [SEL_W-1:0]  a_sel;
    logic [SEL_W-1:0]  b_sel;
    logic [DATA_W-1:0] a_op;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] pe_out_d;
    logic [DATA_W-1:0] pe_out_q;

    assign opcode = bus.pex_config[OPC_LSB +: OPC_W];
    assign b_sel  = bus.pex_config[BSEL_LSB +: SEL_W];
    assign a_sel  = bus.pex_config[ASEL_LSB +: SEL_W];

    // Operand selection; feedback reads the registered result, so no comb loop
    always_comb begin
        a_op = '0;
        b_op = '0;
        unique case (a_sel)
            SEL_OP0: a_op = bus.op_0;
            SEL_OP1: a_op = bus.op_1;
            SEL_OP2: a_op = bus.op_2;
            SEL_FB:  a_op = pe_out_q;
            default: a_op = '0;
        endcase
        unique case (b_sel)
            SEL_OP0: b_op = bus.op_0;
            SEL_OP1: b_op = bus.op_1;
            SEL_OP2: b_op = bus.op_2;
            SEL_FB:  b_op = pe_out_q;
            default: b_op = '0;
        endcase
    end

    pe_alu u_alu (
        .a_i      (a_op),
        .b_i      (b_op),
        .opcode_i (opcode),
        .result_o (pe_out_d)
    );

    // Result register, cleared asynchronously by active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pe_out_q <= '0;
        end else begin
            pe_out_q <= pe_out_d;
        end
    end

    assign bus.pe_out = pe_out_q;

endmodule

// File: tb/tb_cgra_pe.sv
// Self-checking bench for cgra_pe: directed vectors plus randomized configs
// checked against an integer-arithmetic reference model.
// Honours PE_SAT_EN when the design is built with it.
module tb_cgra_pe;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [15:0] model_q;  // reference copy of the registered result

    cgra_pe_if bus ();

    cgra_pe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ALU in plain integer arithmetic
    function automatic logic [15:0] ref_alu(input int opc, input logic [15:0] a,
                                            input logic [15:0] b);
        int sa;
        int sb;
        int r;
        logic [3:0] sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[3:0];
        case (opc)
            0: return a;
            1: r = sa + sb;
            2: r = sa - sb;
            3: r = sa * sb;
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            default: return a << sh;
        endcase
`ifdef PE_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    function automatic logic [15:0] pick(input int sel, input logic [15:0] o0,
                                         input logic [15:0] o1, input logic [15:0] o2,
                                         input logic [15:0] fb);
        case (sel)
            0: return o0;
            1: return o1;
            2: return o2;
            default: return fb;
        endcase
    endfunction

    // Drive one cycle's inputs at negedge, advance the model, settle after posedge
    task automatic run_cycle(input logic [15:0] o0, input logic [15:0] o1,
                             input logic [15:0] o2, input logic [6:0] cfg);
        logic [15:0] a;
        logic [15:0] b;
        @(negedge clk);
        bus.op_0       = o0;
        bus.op_1       = o1;
        bus.op_2       = o2;
        bus.pex_config = cfg;
        a = pick(int'(cfg[1:0]), o0, o1, o2, model_q);
        b = pick(int'(cfg[3:2]), o0, o1, o2, model_q);
        model_q = ref_alu(int'(cfg[6:4]), a, b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_q = '0;
        reset   = 1'b1;
        bus.op_0 = 16'd10000;
        bus.op_1 = '0;
        bus.op_2 = '0;
        bus.pex_config = 7'($urandom);

        // Async reset with no clock edge (first posedge is at t=5)
        #1 reset = 1'b0;
        #2;
        check_eq("reset_async", bus.pe_out, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_hold", bus.pe_out, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // ADD then accumulate via feedback
        run_cycle(16'd10000, 16'd0, 16'd10000, 7'b0010010);
        check_eq("add_op2_op0", bus.pe_out, 16'd20000);
        run_cycle(16'd0, 16'd10000, 16'd0, 7'b0011101);
        check_eq("acc_fb", bus.pe_out, 16'd30000);

        // Mid-operation reset discards the accumulator
        #1 reset = 1'b0;
        #1;
        check_eq("reset_mid", bus.pe_out, 16'h0000);
        model_q = '0;
        #1 reset = 1'b1;
        run_cycle(16'd5, 16'd0, 16'd0, 7'b0010011);  // ADD A=fb B=op_0
        check_eq("fb_after_reset", bus.pe_out, 16'd5);

        // SUB / PASS
        run_cycle(16'd5, 16'd7, 16'd0, 7'b0100100);
        check_eq("sub", bus.pe_out, 16'hFFFE);
        run_cycle(16'd0, 16'd0, 16'hABCD, 7'b0000010);
        check_eq("pass", bus.pe_out, 16'hABCD);

        // Logic / shift, A=op_0 B=op_1
        run_cycle(16'hF0F0, 16'h0FF0, 16'h0, 7'b1000100);
        check_eq("and", bus.pe_out, 16'h00F0);
        run_cycle(16'hF0F0, 16'h0FF0, 16'h0, 7'b1010100);
        check_eq("or", bus.pe_out, 16'hFFF0);
        run_cycle(16'hF0F0, 16'h0FF0, 16'h0, 7'b1100100);
        check_eq("xor", bus.pe_out, 16'hFF00);
        run_cycle(16'hF0F0, 16'h0FF0, 16'h0, 7'b1110100);
        check_eq("shl0", bus.pe_out, 16'hF0F0);
        run_cycle(16'h0003, 16'h0014, 16'h0, 7'b1110100);
        check_eq("shl4", bus.pe_out, 16'h0030);

        // Same source on both sides
        run_cycle(16'd1234, 16'hFFFF, 16'hFFFF, 7'b0010000);
        check_eq("add_same", bus.pe_out, 16'd2468);

        // MUL and overflow boundaries
        run_cycle(16'd300, 16'd300, 16'd0, 7'b0110100);
`ifdef PE_SAT_EN
        check_eq("mul_300", bus.pe_out, 16'h7FFF);
`else
        check_eq("mul_300", bus.pe_out, 16'd24464);
`endif
        run_cycle(16'd30000, 16'd30000, 16'd0, 7'b0010100);
`ifdef PE_SAT_EN
        check_eq("add_ovf", bus.pe_out, 16'h7FFF);
`else
        check_eq("add_ovf", bus.pe_out, 16'hEA60);
`endif
        run_cycle(16'(-30000), 16'd30000, 16'd0, 7'b0100100);
`ifdef PE_SAT_EN
        check_eq("sub_ovf", bus.pe_out, 16'h8000);
`else
        check_eq("sub_ovf", bus.pe_out, 16'h15A0);
`endif

        // Randomized configs and operands, including feedback chains
        for (int i = 0; i < 300; i++) begin
            logic [15:0] r0;
            logic [15:0] r1;
            logic [15:0] r2;
            r0 = ($urandom_range(0, 3) == 0) ? 16'(16'h7FF0 + $urandom_range(0, 31))
                                             : 16'($urandom);
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            run_cycle(r0, r1, r2, 7'($urandom));
            check_eq("random", bus.pe_out, model_q);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
